// File: rtl/seq_pipe_adder.sv
// -----------------------------------------------------------------------------
// seq_pipe_adder
//
// Purpose
//   Pipelined ripple-by-slice adder/subtractor. A WIDTH-bit operation is split
//   into STAGES = WIDTH/SLICE slices. Stage k adds slice k using the carry that
//   stage k-1 registered, so one slice is resolved per clock. The carry chain
//   per cycle is therefore only SLICE bits long. A new operation may enter
//   every cycle. A valid/ready handshake on the output stalls the whole pipe
//   as one unit.
//
// Parameters
//   WIDTH  operand / result width; must be a positive multiple of SLICE
//   SLICE  bits resolved per pipeline stage
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_n_i      synchronous active-low reset
//   in_valid_i   operand set present on A_i, B_i, C_i, SUB_i
//   in_ready_o   operand set is accepted this cycle (when in_valid_i=1)
//   A_i, B_i     operands (unsigned or two's complement)
//   C_i          carry-in (add) / borrow-in (subtract)
//   SUB_i        0 = A+B+C, 1 = A-B-C
//   out_valid_o  S_o/C_o/V_o hold a result
//   out_ready_i  downstream takes the result this cycle
//   S_o          sum / difference
//   C_o          carry-out of MSB (subtract: 1 = no borrow)
//   V_o          signed overflow
// -----------------------------------------------------------------------------
module seq_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
    input  logic             SUB_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o,
    output logic             V_o
);

    localparam int STAGES = WIDTH / SLICE;

    // Whole pipe moves together: it may shift whenever the output slot is
    // empty or is being drained this cycle.
    logic advance;

    // Pipeline taps. Index 0 is the (combinational) entry point fed from the
    // inputs. Index k+1 is the register output of stage k, so index STAGES
    // is the output register.
    logic             vld_w [STAGES+1];
    logic             cy_w  [STAGES+1];
    logic [WIDTH-1:0] a_w   [STAGES+1];
    logic [WIDTH-1:0] b_w   [STAGES+1];
    logic [WIDTH-1:0] s_w   [STAGES+1];

    logic v_d;
    logic v_q;

    assign advance = !out_valid_o || out_ready_i;

    // During reset the pipe is being flushed anyway. Report ready so that
    // an upstream source does not stall on us; whatever it offers is dropped
    // by the reset branch of every stage register.
    assign in_ready_o = advance || !rst_n_i;

    // Subtraction is A + ~B + ~C. Inverting B and the carry once at the entry
    // lets every stage be a plain adder. The effective B travels down the pipe
    // so that the last stage can evaluate overflow against it.
    assign vld_w[0] = in_valid_i;
    assign a_w[0]   = A_i;
    assign b_w[0]   = SUB_i ? ~B_i : B_i;
    assign cy_w[0]  = SUB_i ? ~C_i : C_i;
    assign s_w[0]   = '0;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [SLICE:0]   slice_add;
            logic [WIDTH-1:0] sum_d;
            logic             cy_d;

            logic             vld_q;
            logic             cy_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;

            // One SLICE-bit add with the carry registered by the stage before.
            assign slice_add = {1'b0, a_w[gi][gi*SLICE +: SLICE]}
                             + {1'b0, b_w[gi][gi*SLICE +: SLICE]}
                             + {{SLICE{1'b0}}, cy_w[gi]};
            assign cy_d = slice_add[SLICE];

            // Finished slices ride along. This stage fills in its own slice.
            always_comb begin
                sum_d                    = s_w[gi];
                sum_d[gi*SLICE +: SLICE] = slice_add[SLICE-1:0];
            end

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    vld_q <= 1'b0;
                    cy_q  <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                end else if (advance) begin
                    vld_q <= vld_w[gi];
                    cy_q  <= cy_d;
                    a_q   <= a_w[gi];
                    b_q   <= b_w[gi];
                    s_q   <= sum_d;
                end
            end

            assign vld_w[gi+1] = vld_q;
            assign cy_w[gi+1]  = cy_q;
            assign a_w[gi+1]   = a_q;
            assign b_w[gi+1]   = b_q;
            assign s_w[gi+1]   = s_q;

            // The MSB slice is resolved in the last stage, so overflow is
            // decided there. It is registered alongside the final sum.
            if (gi == STAGES - 1) begin : g_ovf
                assign v_d = (a_w[gi][WIDTH-1] == b_w[gi][WIDTH-1])
                          && (sum_d[WIDTH-1] != a_w[gi][WIDTH-1]);
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            v_q <= 1'b0;
        end else if (advance) begin
            v_q <= v_d;
        end
    end

    assign out_valid_o = vld_w[STAGES];
    assign S_o         = s_w[STAGES];
    assign C_o         = cy_w[STAGES];
    assign V_o         = v_q;

endmodule

// File: tb/tb_seq_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_pipe_adder
//
// Directed bench for seq_pipe_adder.
//   * u_dut  : WIDTH=16, SLICE=4 (four stages). It runs a table of single
//              operations, then a stalled burst and a reset-in-flight
//              sequence.
//   * u_dut4 : WIDTH=4, SLICE=4 (one stage). It runs every add combination
//              back to back.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge. The rising edge is left to the DUT.
// -----------------------------------------------------------------------------
module tb_seq_pipe_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        ev;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, s;
    logic        cin, sub, co, vo;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, s4;
    logic        cin4, sub4, co4, vo4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_pipe_adder #(.WIDTH(16), .SLICE(4)) u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .A_i         (a),
        .B_i         (b),
        .C_i         (cin),
        .SUB_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .S_o         (s),
        .C_o         (co),
        .V_o         (vo)
    );

    seq_pipe_adder #(.WIDTH(4), .SLICE(4)) u_dut4 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid4),
        .in_ready_o  (in_ready4),
        .A_i         (a4),
        .B_i         (b4),
        .C_i         (cin4),
        .SUB_i       (sub4),
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready4),
        .S_o         (s4),
        .C_o         (co4),
        .V_o         (vo4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One isolated operation with out_ready held high. It checks acceptance,
    // latency, the result, and that the result is shown only once.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (lat < 20 && !seen) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, ".seen"}, {31'd0, seen}, 32'd1);
        chk({tag, ".lat"}, lat, 32'd4);
        chk({tag, ".S"}, {16'd0, s}, {16'd0, v.es});
        chk({tag, ".C"}, {31'd0, co}, {31'd0, v.ec});
        chk({tag, ".V"}, {31'd0, vo}, {31'd0, v.ev});
        $display("op %s: A=%h B=%h cin=%b sub=%b -> S=%h C=%b V=%b lat=%0d",
                 tag, v.a, v.b, v.cin, v.sub, s, co, vo, lat);
        @(negedge clk);
        chk({tag, ".once"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [11];
        logic [15:0] st_a [4];
        logic [15:0] st_e [4];
        int          idx;
        int          cnt;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[3]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[10] = '{16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.S", {16'd0, s}, 32'd0);
        chk("rst.C", {31'd0, co}, 32'd0);
        chk("rst.V", {31'd0, vo}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid4", {31'd0, out_valid4}, 32'd0);

        // Table of isolated operations
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Four back-to-back ops. The first result is then stalled for 3 cycles.
        for (int i = 0; i < 4; i++) begin
            st_a[i] = 16'h1111 * 16'(i + 1);
            st_e[i] = st_a[i] + 16'h0F0F;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = st_a[i]; b = 16'h0F0F; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall.first_valid", {31'd0, out_valid}, 32'd1);
        chk("stall.first_S", {16'd0, s}, {16'd0, st_e[0]});
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("stall%0d.valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d.S", k), {16'd0, s}, {16'd0, st_e[0]});
        end
        out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (out_valid) begin
                if (idx < 4) begin
                    chk($sformatf("burst%0d.S", idx), {16'd0, s}, {16'd0, st_e[idx]});
                    $display("burst result %0d: S=%h", idx, s);
                end
                idx++;
            end
            @(negedge clk);
        end
        chk("burst.count", idx, 32'd4);

        // Reset with three operations in flight. Offer a fourth during reset.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'h0101 * 16'(i + 1); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        a = 16'h5555; b = 16'h2222; rst_n = 1'b0;
        #1;
        chk("inrst.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("postrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("postrst.S", {16'd0, s}, 32'd0);
        chk("postrst.C", {31'd0, co}, 32'd0);
        chk("postrst.V", {31'd0, vo}, 32'd0);
        cnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        chk("postrst.dropped", cnt, 32'd0);
        run_vec('{16'h2468, 16'h1357, 1'b1, 1'b0, 16'h37C0, 1'b0, 1'b0}, "postrst_op");

        // WIDTH=4 single stage: every add combination, one per cycle, latency 1.
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (i > 0) begin
                int p;
                logic [4:0] e;
                p = i - 1;
                e = 5'(p[3:0]) + 5'(p[7:4]) + 5'(p[8]);
                chk($sformatf("w4_%0d.valid", p), {31'd0, out_valid4}, 32'd1);
                chk($sformatf("w4_%0d.sum", p), {27'd0, co4, s4}, {27'd0, e});
            end
            if (i < 512) begin
                a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; in_valid4 = 1'b1;
            end else begin
                in_valid4 = 1'b0;
            end
        end
        $display("w4 exhaustive: 512 operations streamed");
        @(negedge clk);
        chk("w4.drain", {31'd0, out_valid4}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_pipe_adder.md
SEQ_PIPE_ADDER -- requirements
Module: seq_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a positive multiple of SLICE.
REQ-002 Parameter SLICE, default 4: bits resolved per pipeline stage; STAGES = WIDTH/SLICE SHALL be derived, not a parameter.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n_i  input  1  reset, synchronous, active-low.
REQ-005 in_valid_i  input  1  operand set present on A_i, B_i, C_i, SUB_i.
REQ-006 in_ready_o  output  1  block accepts the operand set this cycle.
REQ-007 A_i  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 B_i  input  WIDTH  operand B.
REQ-009 C_i  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 SUB_i  input  1  0 = add, 1 = subtract.
REQ-011 out_valid_o  output  1  result on S_o, C_o, V_o is valid.
REQ-012 out_ready_i  input  1  downstream accepts the result this cycle.
REQ-013 S_o  output  WIDTH  sum / difference.
REQ-014 C_o  output  1  carry-out of MSB (subtract: 1 = no borrow).
REQ-015 V_o  output  1  signed two's-complement overflow.

Function
REQ-016 Add: {C_o,S_o} SHALL equal A_i + B_i + C_i, computed at WIDTH+1 bits.
REQ-017 Subtract: {C_o,S_o} SHALL equal A_i + ~B_i + ~C_i, i.e. S_o = A_i - B_i - C_i mod 2^WIDTH.
REQ-018 V_o SHALL be 1 exactly when the MSBs of A_i and the effective B (B_i, or ~B_i when SUB_i=1) are equal and the MSB of S_o differs from them.
REQ-019 Stage k (0..STAGES-1) SHALL add bits [k*SLICE +: SLICE] using the carry registered from stage k-1; stage 0 uses the effective carry-in.
REQ-020 Each stage SHALL register its partial sum slice, its carry, a valid bit, and the operand slices still to be processed; finished sum slices travel with the operation.
REQ-021 advance = !out_valid_o || out_ready_i; all stage registers SHALL update only when advance=1 and SHALL hold otherwise.
REQ-022 in_ready_o SHALL equal advance; an operand set is accepted only when in_valid_i && in_ready_o.
REQ-023 Latency SHALL be STAGES cycles from acceptance to out_valid_o when there is no stall; throughput SHALL be one operation per cycle.
REQ-024 An operation SHALL be presented on the output exactly once, completed on the cycle out_valid_o && out_ready_i; outputs SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-025 Bubbles (advance=1 with in_valid_i=0) SHALL propagate as valid=0 stages; ordering SHALL be preserved.
REQ-026 Simultaneous accept and complete in one cycle SHALL lose no operation and duplicate none.
REQ-027 STAGES=1 SHALL give a single registered stage, latency 1, with identical arithmetic.
REQ-028 S_o, C_o and V_o SHALL be registered outputs; there SHALL be no combinational path from A_i, B_i, C_i or SUB_i to any output.

Reset
REQ-029 When rst_n_i=0 at a rising edge, all valid bits SHALL clear, out_valid_o=0, and S_o, C_o, V_o SHALL be 0 on the following cycle.
REQ-030 While rst_n_i=0, in_ready_o SHALL be 1; inputs sampled during reset SHALL be discarded.
REQ-031 Reset during operation SHALL drop all in-flight operations with no output.

Verification (WIDTH=16, SLICE=4 unless stated)
REQ-032 Add 0xFFFF + 0x0001, C_i=0, out_ready_i=1 -> 4 cycles later S_o=0x0000, C_o=1, V_o=0, out_valid_o for 1 cycle.
REQ-033 Add 0x7FFF + 0x0001 -> S_o=0x8000, C_o=0, V_o=1; subtract 0x8000 - 0x0001, C_i=0 -> S_o=0x7FFF, C_o=1, V_o=1.
REQ-034 Subtract 0x0003 - 0x0005, C_i=1 -> S_o=0xFFFD, C_o=0, V_o=0.
REQ-035 Four back-to-back operations, out_ready_i held 0 for 3 cycles after the first result -> in_ready_o=0 and outputs held during the stall; all four results leave in order, none lost or repeated.
REQ-036 Reset asserted for 1 cycle with 3 operations in flight -> no out_valid_o for those operations; a new operation accepted after reset completes with latency 4.
REQ-037 WIDTH=4, SLICE=4: all 512 combinations of A_i, B_i and C_i in add mode -> {C_o,S_o} = A_i+B_i+C_i, latency 1, one result per cycle.
